dfx_decouple_ctrl: RTL and testbench
====================================

# dfx_decouple_ctrl

Sequencer for the DFX decoupler on the 128-bit AXI4 reconfigurable-partition port. On a decouple request it drains the port before it asserts `decouple`: it blocks new AW/AR issue, waits until every accepted burst has completed, and only then asserts `decouple`. On release it recouples and waits for status before it reopens the port. It sits in the static region, snoops the static-side handshakes and gates AWVALID/ARVALID upstream of the decoupler.

## Interface
- `CntWidth`, 8: width of the outstanding-transaction counters.
- `DrainTimeout`, 0: cycles allowed in DRAIN before a forced decouple; 0 disables the timeout.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `decouple_req_i`  in  1  level request; 1 = decouple the RP, 0 = couple it.
- `aw_valid_i`, `aw_ready_i`, `w_valid_i`, `w_ready_i`, `w_last_i`, `b_valid_i`, `b_ready_i`, `ar_valid_i`, `ar_ready_i`, `r_valid_i`, `r_ready_i`, `r_last_i`  in  1 each  static-side handshake snoop, taken after gating.
- `block_aw_o`  out  1  upstream forces AWVALID=0 and AWREADY=0 while high.
- `block_ar_o`  out  1  same for AR.
- `decouple_o`  out  1  drives decoupler `decouple`.
- `decouple_status_i`  in  1  decoupler `decouple_status`.
- `decoupled_o`  out  1  RP isolated; safe to reconfigure.
- `busy_o`  out  1  FSM not in COUPLED or DECOUPLED.
- `drain_timeout_o`  out  1  sticky; a forced decouple occurred.

## Operation
- Counters, all cleared by reset:
  - `wr_out` (unsigned): +1 on AW fire, −1 on B fire.
  - `rd_out` (unsigned): +1 on AR fire, −1 on R fire with `r_last_i`.
  - `w_bal` (signed, CntWidth+1 bits): +1 on AW fire, −1 on W fire with `w_last_i`. A negative value is legal because W may lead AW.
  - Simultaneous increment and decrement leaves a counter unchanged.
- Saturation guard: `block_aw_o` is also high when `wr_out` is all-ones; `block_ar_o` is also high when `rd_out` is all-ones. Counters never wrap.
- Quiescent = `wr_out`==0, `rd_out`==0, `w_bal`==0 and `w_valid_i`==0, all evaluated on registered values.
- FSM states COUPLED, DRAIN, ISOLATE, DECOUPLED, RECOUPLE.
  - COUPLED → DRAIN when `decouple_req_i`=1.
  - DRAIN → ISOLATE when quiescent, or when the timeout expires (timeout also sets `drain_timeout_o`). DRAIN → COUPLED if `decouple_req_i` drops before quiescence (abort).
  - ISOLATE → DECOUPLED when `decouple_status_i`=1.
  - DECOUPLED → RECOUPLE when `decouple_req_i`=0.
  - RECOUPLE → COUPLED when `decouple_status_i`=0.
- Outputs per state:
  - COUPLED: `decouple_o`=0; blocks follow the saturation guard only.
  - DRAIN: `decouple_o`=0; both blocks high.
  - ISOLATE, DECOUPLED, RECOUPLE: `decouple_o`=1 in ISOLATE and DECOUPLED, 0 in RECOUPLE; both blocks high.
  - `decoupled_o`=1 in DECOUPLED only.
- A request asserted again during RECOUPLE is held until the FSM reaches COUPLED; the FSM then re-enters DRAIN on the next cycle.
- Counters are frozen while `decouple_o`=1 or during RECOUPLE. The decoupler absorbs any stray traffic, so it is not counted.
- `drain_timeout_o` clears only on reset or on COUPLED → DRAIN.
- Reset mid-operation: all state is lost. The AXI master and the RP must be reset together with this block.

## Timing
- All outputs are registered. Reset values: `block_aw_o`=0, `block_ar_o`=0, `decouple_o`=0, `decoupled_o`=0, `busy_o`=0, `drain_timeout_o`=0, FSM=COUPLED.
- Request to blocks high: 1 cycle. An AW/AR fire in the same cycle that the request is sampled is still counted and drained.
- Last completion to `decouple_o`=1: 2 cycles (counter update, then quiescent detect and transition).
- `decoupled_o` rises 1 cycle after `decouple_status_i` is sampled high.
- Blocks fall 1 cycle after `decouple_status_i` is sampled low in RECOUPLE.
- The timeout counter starts on DRAIN entry and fires after exactly `DrainTimeout` cycles in DRAIN.

## Structure
- Package `dfx_pkg`: state enum `dfx_state_e`, plus a response-code constant shared with the decoupler (`RespSlverr`=2'b10).
- One sub-module, `dfx_outstanding_cnt` (up/down saturating counter, parameterised width and signedness), instantiated three times.

## Test plan
- Idle port, request high → `decouple_o`=1 two cycles after the request, `decoupled_o`=1 once status is high; release → blocks low 1 cycle after status falls.
- 3 writes of AWLEN=3 outstanding, B responses delayed 20 cycles → `decouple_o` stays 0 until the third B, then rises 2 cycles later.
- W burst accepted 5 cycles before its AW (`w_bal`=−1) while draining → no decouple until the AW fires and `w_bal` returns to 0.
- `DrainTimeout`=16, one read whose R never arrives → ISOLATE at DRAIN cycle 16, `drain_timeout_o`=1 and sticky.
- Request dropped while 1 read is outstanding → FSM returns to COUPLED, blocks released, `decouple_o` never asserted.
- `CntWidth`=2 with 3 ARs outstanding → `block_ar_o`=1; the 4th AR is held until an R with `r_last_i` fires.

Source files
------------

// File: rtl/dfx_pkg.sv
// Shared definitions for the DFX decoupler sequencer on the RP AXI4 port.
package dfx_pkg;

    typedef enum logic [2:0] {
        COUPLED,
        DRAIN,
        ISOLATE,
        DECOUPLED,
        RECOUPLE
    } dfx_state_e;

    // Response code the decoupler returns for transactions it absorbs.
    localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/dfx_outstanding_cnt.sv
// Up/down counter that saturates at both ends, optionally two's-complement signed.
module dfx_outstanding_cnt #(
    parameter int Width  = 8,
    parameter bit Signed = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic atMaxNext_o
);

    localparam logic [Width-1:0] MaxVal = Signed ? {1'b0, {(Width-1){1'b1}}} : {Width{1'b1}};
    localparam logic [Width-1:0] MinVal = Signed ? {1'b1, {(Width-1){1'b0}}} : {Width{1'b0}};
    localparam logic [Width-1:0] One    = Width'(1);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Step the count unless inc and dec coincide, frozen, or already at a limit.
    always_comb begin
        count_d = count_q;
        if (en_i && inc_i && !dec_i && (count_q != MaxVal)) begin
            count_d = count_q + One;
        end else if (en_i && dec_i && !inc_i && (count_q != MinVal)) begin
            count_d = count_q - One;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o      = (count_q == '0);
    // Looks at the next value so a registered block can close the port before a further fire.
    assign atMaxNext_o = (count_d == MaxVal);

endmodule

// File: rtl/dfx_decouple_ctrl.sv
// Drains the RP AXI4 port before asserting decouple, and reopens it after recoupling.
module dfx_decouple_ctrl
    import dfx_pkg::*;
#(
    parameter int CntWidth     = 8,
    parameter int DrainTimeout = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic decouple_req_i,
    input  logic aw_valid_i,
    input  logic aw_ready_i,
    input  logic w_valid_i,
    input  logic w_ready_i,
    input  logic w_last_i,
    input  logic b_valid_i,
    input  logic b_ready_i,
    input  logic ar_valid_i,
    input  logic ar_ready_i,
    input  logic r_valid_i,
    input  logic r_ready_i,
    input  logic r_last_i,
    output logic block_aw_o,
    output logic block_ar_o,
    output logic decouple_o,
    input  logic decouple_status_i,
    output logic decoupled_o,
    output logic busy_o,
    output logic drain_timeout_o
);

    localparam int TmrWidth = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'((DrainTimeout > 0) ? (DrainTimeout - 1) : 0);
    localparam logic [TmrWidth-1:0] TmrOne  = TmrWidth'(1);

    dfx_state_e state_q, state_d;
    logic [TmrWidth-1:0] tmr_q, tmr_d;
    logic blockAw_q, blockAr_q, decouple_q, decoupled_q, busy_q, timeout_q;
    logic timeoutFire;

    logic awFire, wLastFire, bFire, arFire, rLastFire;
    logic cntEn;
    logic wrZero, rdZero, balZero;
    logic wrAtMax, rdAtMax, balAtMax;
    logic quiescent, timeoutHit;

    assign awFire    = aw_valid_i & aw_ready_i;
    assign wLastFire = w_valid_i & w_ready_i & w_last_i;
    assign bFire     = b_valid_i & b_ready_i;
    assign arFire    = ar_valid_i & ar_ready_i;
    assign rLastFire = r_valid_i & r_ready_i & r_last_i;

    // Traffic reaching the isolated RP is absorbed by the decoupler, so it is not counted.
    assign cntEn = !decouple_q && (state_q != RECOUPLE);

    dfx_outstanding_cnt #(.Width(CntWidth), .Signed(1'b0)) u_wr_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (cntEn),
        .inc_i       (awFire),
        .dec_i       (bFire),
        .zero_o      (wrZero),
        .atMaxNext_o (wrAtMax)
    );

    dfx_outstanding_cnt #(.Width(CntWidth), .Signed(1'b0)) u_rd_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (cntEn),
        .inc_i       (arFire),
        .dec_i       (rLastFire),
        .zero_o      (rdZero),
        .atMaxNext_o (rdAtMax)
    );

    // Goes negative when W data leads its AW.
    dfx_outstanding_cnt #(.Width(CntWidth + 1), .Signed(1'b1)) u_wbal_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (cntEn),
        .inc_i       (awFire),
        .dec_i       (wLastFire),
        .zero_o      (balZero),
        .atMaxNext_o (balAtMax)
    );

    assign quiescent  = wrZero && rdZero && balZero && !w_valid_i;
    assign timeoutHit = (DrainTimeout != 0) && (tmr_q == TmrLast);

    // Next-state selection; a drained port wins over an abort, an abort wins over a timeout.
    always_comb begin
        state_d     = state_q;
        timeoutFire = 1'b0;
        case (state_q)
            COUPLED: begin
                if (decouple_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (quiescent) begin
                    state_d = ISOLATE;
                end else if (!decouple_req_i) begin
                    state_d = COUPLED;
                end else if (timeoutHit) begin
                    state_d     = ISOLATE;
                    timeoutFire = 1'b1;
                end
            end
            ISOLATE: begin
                if (decouple_status_i) state_d = DECOUPLED;
            end
            DECOUPLED: begin
                if (!decouple_req_i) state_d = RECOUPLE;
            end
            RECOUPLE: begin
                if (!decouple_status_i) state_d = COUPLED;
            end
            default: state_d = COUPLED;
        endcase
        tmr_d = ((state_q == DRAIN) && (state_d == DRAIN)) ? (tmr_q + TmrOne) : '0;
    end

    // State, drain timer and registered outputs, all derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COUPLED;
            tmr_q       <= '0;
            blockAw_q   <= 1'b0;
            blockAr_q   <= 1'b0;
            decouple_q  <= 1'b0;
            decoupled_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            blockAw_q   <= (state_d != COUPLED) || wrAtMax || balAtMax;
            blockAr_q   <= (state_d != COUPLED) || rdAtMax;
            decouple_q  <= (state_d == ISOLATE) || (state_d == DECOUPLED);
            decoupled_q <= (state_d == DECOUPLED);
            busy_q      <= (state_d != COUPLED) && (state_d != DECOUPLED);
            if ((state_q == COUPLED) && (state_d == DRAIN)) begin
                timeout_q <= 1'b0;
            end else if (timeoutFire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign block_aw_o      = blockAw_q;
    assign block_ar_o      = blockAr_q;
    assign decouple_o      = decouple_q;
    assign decoupled_o     = decoupled_q;
    assign busy_o          = busy_q;
    assign drain_timeout_o = timeout_q;

endmodule

// File: tb/tb_dfx_decouple_ctrl.sv
// Directed bench: dutA uses default parameters, dutB uses CntWidth=2 and DrainTimeout=16.
module tb_dfx_decouple_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic status = 1'b0;
    logic awValid = 1'b0, awReady = 1'b0, wValid = 1'b0, wReady = 1'b0, wLast = 1'b0;
    logic bValid = 1'b0, bReady = 1'b0, arValid = 1'b0, arReady = 1'b0;
    logic rValid = 1'b0, rReady = 1'b0, rLast = 1'b0;

    logic blockAwA, blockArA, decoupleA, decoupledA, busyA, timeoutA;
    logic blockAwB, blockArB, decoupleB, decoupledB, busyB, timeoutB;

    int assertCount = 0;
    int failCount = 0;
    int earlyCount;

    always #5 clk = ~clk;

    dfx_decouple_ctrl #(.CntWidth(8), .DrainTimeout(0)) dutA (
        .clk_i(clk), .rst_i(rst), .decouple_req_i(req),
        .aw_valid_i(awValid), .aw_ready_i(awReady),
        .w_valid_i(wValid), .w_ready_i(wReady), .w_last_i(wLast),
        .b_valid_i(bValid), .b_ready_i(bReady),
        .ar_valid_i(arValid), .ar_ready_i(arReady),
        .r_valid_i(rValid), .r_ready_i(rReady), .r_last_i(rLast),
        .block_aw_o(blockAwA), .block_ar_o(blockArA),
        .decouple_o(decoupleA), .decouple_status_i(status),
        .decoupled_o(decoupledA), .busy_o(busyA), .drain_timeout_o(timeoutA)
    );

    dfx_decouple_ctrl #(.CntWidth(2), .DrainTimeout(16)) dutB (
        .clk_i(clk), .rst_i(rst), .decouple_req_i(req),
        .aw_valid_i(awValid), .aw_ready_i(awReady),
        .w_valid_i(wValid), .w_ready_i(wReady), .w_last_i(wLast),
        .b_valid_i(bValid), .b_ready_i(bReady),
        .ar_valid_i(arValid), .ar_ready_i(arReady),
        .r_valid_i(rValid), .r_ready_i(rReady), .r_last_i(rLast),
        .block_aw_o(blockAwB), .block_ar_o(blockArB),
        .decouple_o(decoupleB), .decouple_status_i(status),
        .decoupled_o(decoupledB), .busy_o(busyB), .drain_timeout_o(timeoutB)
    );

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a set of complete handshakes (valid and ready together) for the next edge.
    task automatic applyStimulus(input logic aw, input logic w, input logic wl, input logic b,
                                 input logic ar, input logic r, input logic rl);
        awValid = aw; awReady = aw;
        wValid  = w;  wReady  = w;  wLast = wl;
        bValid  = b;  bReady  = b;
        arValid = ar; arReady = ar;
        rValid  = r;  rReady  = r;  rLast = rl;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 1'b0;
        status = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        tick();
        checkOutput("rst_block_aw", blockAwA, 1'b0);
        checkOutput("rst_block_ar", blockArA, 1'b0);
        checkOutput("rst_decouple", decoupleA, 1'b0);
        checkOutput("rst_decoupled", decoupledA, 1'b0);
        checkOutput("rst_busy", busyA, 1'b0);
        checkOutput("rst_timeout", timeoutB, 1'b0);
        rst = 1'b0;
        tick();

        $display("[TB] idle port decouple and release");
        req = 1'b1;
        tick();
        checkOutput("t1_block_aw", blockAwA, 1'b1);
        checkOutput("t1_block_ar", blockArA, 1'b1);
        checkOutput("t1_busy", busyA, 1'b1);
        checkOutput("t1_decouple_wait", decoupleA, 1'b0);
        tick();
        checkOutput("t1_decouple", decoupleA, 1'b1);
        checkOutput("t1_decoupled_wait", decoupledA, 1'b0);
        status = 1'b1;
        tick();
        checkOutput("t1_decoupled", decoupledA, 1'b1);
        checkOutput("t1_busy_idle", busyA, 1'b0);
        req = 1'b0;
        tick();
        checkOutput("t1_recouple_dec", decoupleA, 1'b0);
        checkOutput("t1_recouple_blk", blockAwA, 1'b1);
        checkOutput("t1_recouple_dcd", decoupledA, 1'b0);
        status = 1'b0;
        tick();
        checkOutput("t1_open_aw", blockAwA, 1'b0);
        checkOutput("t1_open_ar", blockArA, 1'b0);
        checkOutput("t1_open_busy", busyA, 1'b0);

        $display("[TB] three outstanding writes, delayed B");
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0);
            tick();
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
            applyStimulus(0, 1, 1, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        req = 1'b1;
        tick();
        checkOutput("t2_block_aw", blockAwA, 1'b1);
        earlyCount = 0;
        repeat (16) begin
            tick();
            if (decoupleA) earlyCount++;
        end
        checkOutput("t2_no_early", (earlyCount == 0), 1'b1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            tick();
            checkOutput("t2_partial_b", decoupleA, 1'b0);
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_last_b_plus1", decoupleA, 1'b0);
        tick();
        checkOutput("t2_last_b_plus2", decoupleA, 1'b1);

        $display("[TB] W leads AW while draining");
        doReset();
        req = 1'b1;
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        checkOutput("t3_wbal_neg", decoupleA, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t3_aw_pending_b", decoupleA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        wValid = 1'b1;
        tick();
        checkOutput("t3_wvalid_hold", decoupleA, 1'b0);
        wValid = 1'b0;
        tick();
        checkOutput("t3_decouple", decoupleA, 1'b1);

        $display("[TB] drain timeout with a lost read");
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        req = 1'b1;
        tick();
        repeat (15) tick();
        checkOutput("t4_before_timeout", decoupleB, 1'b0);
        checkOutput("t4_flag_before", timeoutB, 1'b0);
        tick();
        checkOutput("t4_timeout_dec", decoupleB, 1'b1);
        checkOutput("t4_timeout_flag", timeoutB, 1'b1);
        checkOutput("t4_no_timeout_a", decoupleA, 1'b0);
        status = 1'b1;
        tick();
        checkOutput("t4_decoupled", decoupledB, 1'b1);
        req = 1'b0;
        tick();
        status = 1'b0;
        tick();
        checkOutput("t4_reopen", blockArB, 1'b0);
        checkOutput("t4_sticky", timeoutB, 1'b1);
        req = 1'b1;
        tick();
        checkOutput("t4_flag_clear", timeoutB, 1'b0);

        $display("[TB] abort with a read outstanding");
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        req = 1'b1;
        tick();
        checkOutput("t5_block_ar", blockArA, 1'b1);
        tick();
        tick();
        checkOutput("t5_no_decouple", decoupleA, 1'b0);
        req = 1'b0;
        tick();
        checkOutput("t5_abort_aw", blockAwA, 1'b0);
        checkOutput("t5_abort_ar", blockArA, 1'b0);
        checkOutput("t5_abort_busy", busyA, 1'b0);
        checkOutput("t5_abort_dec", decoupleA, 1'b0);

        $display("[TB] read counter saturation");
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        checkOutput("t6_two_ar", blockArB, 1'b0);
        tick();
        checkOutput("t6_three_ar", blockArB, 1'b1);
        checkOutput("t6_aw_open", blockAwB, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("t6_held", blockArB, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick();
        checkOutput("t6_r_not_last", blockArB, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        tick();
        checkOutput("t6_r_last", blockArB, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("t6_fourth_ar", blockArB, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] re-request during recouple, frozen counters");
        doReset();
        req = 1'b1;
        tick();
        tick();
        checkOutput("t7_decouple", decoupleA, 1'b1);
        status = 1'b1;
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        req = 1'b0;
        tick();
        checkOutput("t7_recouple", decoupleA, 1'b0);
        req = 1'b1;
        tick();
        checkOutput("t7_held_blk", blockAwA, 1'b1);
        checkOutput("t7_held_busy", busyA, 1'b1);
        status = 1'b0;
        tick();
        checkOutput("t7_coupled_blk", blockAwA, 1'b0);
        checkOutput("t7_coupled_busy", busyA, 1'b0);
        checkOutput("t7_frozen", blockArB, 1'b0);
        tick();
        checkOutput("t7_redrain_blk", blockAwA, 1'b1);
        checkOutput("t7_redrain_busy", busyA, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
